// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding-select encoding, special register IDs
// and the layout of one in-flight destination slot.
package pipe_pkg;

   localparam int PIPE_REG_W = 6;
   localparam int PIPE_CNT_W = 16;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_EX  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;
   localparam logic [1:0] FWD_WB  = 2'd3;

   localparam logic [PIPE_REG_W-1:0] REG_NONE = 6'd0;
   localparam logic [PIPE_REG_W-1:0] REG_HILO = 6'd33;

   typedef struct packed {
      logic                  valid;
      logic [PIPE_REG_W-1:0] wreg;
      logic                  is_load;
   } slot_t;

   localparam slot_t SLOT_BUBBLE = '{valid: 1'b0, wreg: REG_NONE, is_load: 1'b0};

endpackage

// File: rtl/reg_hazard_scoreboard_slot.sv
// One pipeline destination slot: enabled register with bubble insertion and
// hit compares against both ID read ports.
module hazard_slot
   import pipe_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  bubble,
   input  slot_t                 d,
   input  logic [PIPE_REG_W-1:0] rreg_a,
   input  logic [PIPE_REG_W-1:0] rreg_b,
   output slot_t                 q,
   output logic                  hit_a,
   output logic                  hit_b
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= SLOT_BUBBLE;
      end else if (en) begin
         q <= bubble ? SLOT_BUBBLE : d;
      end
   end

   // Register 0 is "no register" and must never produce a forwarding hit.
   assign hit_a = q.valid && (q.wreg == rreg_a) && (rreg_a != REG_NONE);
   assign hit_b = q.valid && (q.wreg == rreg_b) && (rreg_b != REG_NONE);

endmodule

// File: rtl/reg_hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks EX/MEM/WB destinations, drives operand
// forwarding selects, the load-use stall and a saturating stall counter.
module reg_hazard_scoreboard
   import pipe_pkg::*;
#(
   parameter int REG_W = PIPE_REG_W,
   parameter int CNT_W = PIPE_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rreg_a,
   input  logic [REG_W-1:0] id_rreg_b,
   input  logic [REG_W-1:0] id_wreg,
   input  logic             id_is_load,
   input  logic             hold,
   input  logic             flush,
   output logic             stall,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   slot_t ex_d, ex_q, mem_q, wb_q;
   logic  ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
   logic  advance, ex_bubble;
   logic  unused_wb;

   assign advance   = !hold;
   assign ex_bubble = stall || flush || !id_valid;
   assign ex_d      = '{valid: 1'b1, wreg: id_wreg, is_load: id_is_load};

   hazard_slot u_ex (
      .clk(clk), .rst_n(rst_n), .en(advance), .bubble(ex_bubble), .d(ex_d),
      .rreg_a(id_rreg_a), .rreg_b(id_rreg_b), .q(ex_q), .hit_a(ex_hit_a), .hit_b(ex_hit_b)
   );

   hazard_slot u_mem (
      .clk(clk), .rst_n(rst_n), .en(advance), .bubble(1'b0), .d(ex_q),
      .rreg_a(id_rreg_a), .rreg_b(id_rreg_b), .q(mem_q), .hit_a(mem_hit_a), .hit_b(mem_hit_b)
   );

   hazard_slot u_wb (
      .clk(clk), .rst_n(rst_n), .en(advance), .bubble(1'b0), .d(mem_q),
      .rreg_a(id_rreg_a), .rreg_b(id_rreg_b), .q(wb_q), .hit_a(wb_hit_a), .hit_b(wb_hit_b)
   );

   // WB is the last stage; its contents only matter through its hit compares.
   assign unused_wb = ^wb_q;

   // Youngest producer wins.
   always_comb begin
      fwd_a = FWD_RF;
      if (ex_hit_a)       fwd_a = FWD_EX;
      else if (mem_hit_a) fwd_a = FWD_MEM;
      else if (wb_hit_a)  fwd_a = FWD_WB;

      fwd_b = FWD_RF;
      if (ex_hit_b)       fwd_b = FWD_EX;
      else if (mem_hit_b) fwd_b = FWD_MEM;
      else if (wb_hit_b)  fwd_b = FWD_WB;
   end

   assign stall = id_valid && !flush && ex_q.valid && ex_q.is_load && (ex_hit_a || ex_hit_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall && advance && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Directed bench for reg_hazard_scoreboard: a stage-list reference model is
// compared on every falling edge, plus hand-computed literal expectations.
module tb_reg_hazard_scoreboard;

   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             id_valid = 1'b0;
   logic [5:0]       id_rreg_a = '0;
   logic [5:0]       id_rreg_b = '0;
   logic [5:0]       id_wreg = '0;
   logic             id_is_load = 1'b0;
   logic             hold = 1'b0;
   logic             flush = 1'b0;
   logic             stall;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cnt;

   int checks = 0;
   int failures = 0;

   reg_hazard_scoreboard #(.REG_W(6), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rreg_a(id_rreg_a),
      .id_rreg_b(id_rreg_b), .id_wreg(id_wreg), .id_is_load(id_is_load),
      .hold(hold), .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: index 0 = EX (youngest), 1 = MEM, 2 = WB.
   bit m_valid [3] = '{0, 0, 0};
   int m_wreg  [3] = '{0, 0, 0};
   bit m_load  [3] = '{0, 0, 0};
   int m_cnt = 0;

   function automatic int m_fwd(int r);
      if (r == 0) return 0;
      for (int s = 0; s < 3; s++)
         if (m_valid[s] && m_wreg[s] == r) return s + 1;
      return 0;
   endfunction

   function automatic bit m_stall();
      return id_valid && !flush && m_valid[0] && m_load[0] &&
             (m_fwd(int'(id_rreg_a)) == 1 || m_fwd(int'(id_rreg_b)) == 1);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < 3; s++) begin
            m_valid[s] = 0; m_wreg[s] = 0; m_load[s] = 0;
         end
         m_cnt = 0;
      end else if (!hold) begin
         bit st;
         st = m_stall();
         if (st && m_cnt < CMAX) m_cnt++;
         for (int s = 2; s > 0; s--) begin
            m_valid[s] = m_valid[s-1]; m_wreg[s] = m_wreg[s-1]; m_load[s] = m_load[s-1];
         end
         if (st || flush || !id_valid) begin
            m_valid[0] = 0; m_wreg[0] = 0; m_load[0] = 0;
         end else begin
            m_valid[0] = 1; m_wreg[0] = int'(id_wreg); m_load[0] = id_is_load;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model_stall", int'(stall), int'(m_stall()));
      chk("model_fwd_a", int'(fwd_a), m_fwd(int'(id_rreg_a)));
      chk("model_fwd_b", int'(fwd_b), m_fwd(int'(id_rreg_b)));
      chk("model_cnt", int'(stall_cnt), m_cnt);
   end

   task automatic set(input bit v, input int a, input int b, input int w,
                      input bit ld, input bit h, input bit f);
      id_valid = v; id_rreg_a = 6'(a); id_rreg_b = 6'(b); id_wreg = 6'(w);
      id_is_load = ld; hold = h; flush = f;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      tick();
      rst_n = 1'b1;
      // idle, slots empty
      set(0, 7, 12, 3, 0, 0, 0);
      chk("reset_stall", int'(stall), 0);
      chk("reset_fwd_a", int'(fwd_a), 0);
      chk("reset_fwd_b", int'(fwd_b), 0);
      chk("reset_cnt", int'(stall_cnt), 0);
      tick();

      // ADDU r8 walks down the pipe
      set(1, 1, 2, 8, 0, 0, 0); tick();
      set(1, 8, 0, 0, 0, 0, 0); chk("addu_ex_fwd_a", int'(fwd_a), 1); tick();
      set(1, 0, 8, 0, 0, 0, 0); chk("addu_mem_fwd_b", int'(fwd_b), 2); tick();
      set(1, 8, 8, 0, 0, 0, 0); chk("addu_wb_fwd_a", int'(fwd_a), 3); tick();
      set(1, 8, 0, 0, 0, 0, 0); chk("addu_gone_fwd_a", int'(fwd_a), 0); tick();

      // LW r9 then use in operand B
      set(1, 0, 0, 9, 1, 0, 0); tick();
      set(1, 0, 9, 0, 0, 0, 0);
      chk("lw_stall", int'(stall), 1);
      chk("lw_fwd_b_ex", int'(fwd_b), 1);
      tick();
      set(1, 0, 9, 0, 0, 0, 0);
      chk("lw_after_stall", int'(stall), 0);
      chk("lw_after_fwd_b", int'(fwd_b), 2);
      chk("lw_cnt", int'(stall_cnt), 1);
      tick();
      for (int i = 0; i < 3; i++) begin set(0, 0, 0, 0, 0, 0, 0); tick(); end

      // register 0 never hits, HI/LO does
      set(1, 0, 0, 0, 1, 0, 0); tick();
      set(1, 0, 0, 0, 0, 0, 0);
      chk("r0_stall", int'(stall), 0);
      chk("r0_fwd_a", int'(fwd_a), 0);
      tick();
      set(1, 0, 0, 33, 0, 0, 0); tick();
      set(1, 33, 0, 0, 0, 0, 0); chk("hilo_fwd_a", int'(fwd_a), 1); tick();

      // back-to-back writes of r5, then hold for 3 edges
      set(1, 0, 0, 5, 0, 0, 0); tick();
      set(1, 0, 0, 5, 0, 0, 0); tick();
      set(1, 5, 5, 0, 0, 1, 0); chk("b2b_fwd_a", int'(fwd_a), 1);
      for (int i = 0; i < 3; i++) tick();
      set(1, 5, 5, 0, 0, 1, 0);
      chk("hold_fwd_a", int'(fwd_a), 1);
      chk("hold_fwd_b", int'(fwd_b), 1);
      tick();

      // load-use with flush: flush wins
      set(1, 0, 0, 10, 1, 0, 0); tick();
      set(1, 10, 0, 0, 0, 0, 1); chk("flush_stall", int'(stall), 0); tick();
      set(1, 10, 0, 0, 0, 0, 0);
      chk("flush_fwd_a_mem", int'(fwd_a), 2);
      chk("flush_no_stall", int'(stall), 0);
      tick();

      // hold during stall: counter frozen until the first non-hold edge
      set(1, 0, 0, 11, 1, 0, 0); tick();
      set(1, 11, 0, 0, 0, 1, 0); tick(); tick();
      set(1, 11, 0, 0, 0, 1, 0);
      chk("hold_stall", int'(stall), 1);
      chk("hold_cnt", int'(stall_cnt), 1);
      set(1, 11, 0, 0, 0, 0, 0); tick();
      set(1, 11, 0, 0, 0, 0, 0);
      chk("hold_release_stall", int'(stall), 0);
      chk("hold_release_fwd_a", int'(fwd_a), 2);
      chk("hold_release_cnt", int'(stall_cnt), 2);
      tick();

      // async reset in the middle of a stall
      set(1, 0, 0, 12, 1, 0, 0); tick();
      set(1, 0, 12, 0, 0, 0, 0);
      chk("pre_rst_stall", int'(stall), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_stall", int'(stall), 0);
      chk("rst_fwd_b", int'(fwd_b), 0);
      chk("rst_cnt", int'(stall_cnt), 0);
      tick();
      rst_n = 1'b1;

      // counter saturation
      for (int i = 0; i < CMAX + 3; i++) begin
         set(1, 0, 0, 13, 1, 0, 0); tick();
         set(1, 0, 13, 0, 0, 0, 0); tick();
         set(1, 0, 13, 0, 0, 0, 0); tick();
      end
      set(0, 0, 0, 0, 0, 0, 0);
      chk("sat_cnt", int'(stall_cnt), CMAX);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
